parc_mem_responder: RTL and testbench
=====================================

# parc_mem_responder

Single-port memory responder that terminates one PARCv2 core memory port, either the instruction port or the data port. It accepts packed memory request messages under a val/rdy handshake and performs word, halfword or byte reads and writes on an internal byte-addressed array. It returns packed response messages after a fixed, parameterized latency. Responses are val-only because the core has no response-ready signal, so the block never backpressures on the response side. It is instantiated twice in the test harness, once per core port.

## Interface
- p_mem_sz, 65536: array size in bytes; power of two, multiple of 4.
- p_lat, 2: request-to-response latency in cycles; legal range 1..8.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- memreq_msg  in  67  request fields:
  - [66] type: 0 = read, 1 = write.
  - [65:34] addr: byte address.
  - [33:32] len: 0 = 4 bytes, 1 = 1 byte, 2 = 2 bytes, 3 = 3 bytes.
  - [31:0] data: write data.
- memreq_val  in  1  request valid.
- memreq_rdy  out  1  request ready; low while reset is high, otherwise high.
- memresp_msg  out  35  response fields:
  - [34] type: echo of the request type.
  - [33:32] len: echo of the request len.
  - [31:0] data: read data, or 0 for writes.
- memresp_val  out  1  response valid, one cycle per response.
- err  out  1  sticky error flag; cleared only by reset.

## Operation
- Accept condition: a request is accepted in cycle t when memreq_val && memreq_rdy.
- Byte count: n = len (len 0 means n = 4).
- Illegal request: addr[1:0] + n > 4 (word-crossing), or addr >= p_mem_sz.
  - The request is still accepted and still gets a response.
  - The response has data 0 and the array is not modified.
  - err is set from cycle t+1 onward.
- Read:
  - Bytes addr .. addr+n-1 are returned right-justified in data[8n-1:0].
  - Upper bytes are zero; sign extension is the core's job.
  - The array is read at acceptance, so a read observes every write accepted in earlier cycles.
- Write:
  - data[8n-1:0] is written little-endian to bytes addr .. addr+n-1 at the end of cycle t.
  - The write response carries data 0.
- Ordering: responses come out in acceptance order. One request per cycle is sustainable indefinitely with no bubbles.
- Reset:
  - Clears all pipeline valid bits, memresp_msg and err.
  - In-flight responses are dropped and never emitted.
  - Array contents are not altered by reset; the harness preloads them.

## Timing
- Latency: a request accepted in cycle t produces memresp_val = 1 in cycle t+p_lat exactly.
- Response register: memresp_msg is registered and stable during the valid cycle. It holds its last value (0 after reset) when memresp_val = 0.
- Reset values: memresp_val 0, memresp_msg 0, err 0, memreq_rdy 0.
- After reset: memreq_rdy = 1 in the first cycle with reset low. The first possible response is p_lat cycles after that.
- Reset mid-operation: asserting reset in any cycle t..t+p_lat-1 suppresses the response of a request accepted in cycle t.
- Write-then-read: a write in cycle t followed by a read of the same byte in cycle t+1 returns the new data.
- Simultaneous events: there is no simultaneous read and write, since the block has a single port. Response emission and new acceptance in the same cycle are independent.

## Structure
- Message field offsets, sizes (67, 35) and type codes stay in the existing shared memory-message headers, packed and unpacked with the existing MemReqMsg/MemRespMsg bits helpers.
- The block adds only local constants.
- Sub-module parc_mem_resp_pipe: a p_lat-deep shift register of {val, 35-bit msg} with synchronous clear of the val bits. The top level holds the array, the decode, the illegal-request check and err.

## Test plan
All scenarios use p_lat = 2 unless stated.
1. Word write then read:
   - Write addr 0x1000, len 0, data 0xdeadbeef at t=0 -> resp {type 1, len 0, data 0} at t=2.
   - Read 0x1000 at t=1 -> data 0xdeadbeef at t=3.
2. Byte write merge: after scenario 1, write addr 0x1001, len 1, data 0x000000aa, then read word 0x1000 -> 0xdeadaaef. A halfword read at 0x1002 -> 0x0000dead.
3. Streaming: 8 back-to-back reads of 0x1000..0x101c at t=0..7 -> memresp_val high at t=2..9, in address order, with no gaps.
4. Reset in flight: read 0x1000 accepted at t=0, reset high at t=1 -> no response ever. After reset, reading 0x1000 still returns 0xdeadaaef.
5. Errors:
   - Read 0x00010000 with p_mem_sz 65536 -> data 0, err = 1 from t+1 and held.
   - Halfword write to 0x1003 -> err set, memory unchanged.
   - Reset clears err.
6. p_lat = 1: write 0x2000, data 0x12345678 at t=0, read 0x2000 at t=1 -> responses at t=1 and t=2; the read returns 0x12345678.

Source files
------------

// File: rtl/parc_mem_responder_pkg.sv
// rtl/parc_mem_responder_pkg.sv - memory request/response message layout and helpers
//
// Shared PARCv2 memory message definitions:
//   request  (67 bits): {type[66], addr[65:34], len[33:32], data[31:0]}
//   response (35 bits): {type[34], len[33:32], data[31:0]}
package parc_mem_responder_pkg;

  localparam int unsigned MEMREQ_NBITS  = 67;
  localparam int unsigned MEMRESP_NBITS = 35;

  localparam logic MEM_TYPE_READ  = 1'b0;
  localparam logic MEM_TYPE_WRITE = 1'b1;

  // Field order in the packed structs reproduces the bit offsets above.
  typedef struct packed {
    logic        typ;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_t;

  typedef struct packed {
    logic        typ;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_t;

  function automatic mem_req_t mem_req_unpack(input logic [MEMREQ_NBITS-1:0] bits);
    return mem_req_t'(bits);
  endfunction

  function automatic logic [MEMRESP_NBITS-1:0] mem_resp_pack(
    input logic        typ,
    input logic [1:0]  len,
    input logic [31:0] data
  );
    mem_resp_t r;
    r.typ  = typ;
    r.len  = len;
    r.data = data;
    return r;
  endfunction

  // len encodes the byte count modulo 4: 0 stands for a full word.
  function automatic logic [2:0] mem_len_bytes(input logic [1:0] len);
    return (len == 2'd0) ? 3'd4 : {1'b0, len};
  endfunction

endpackage

// File: rtl/parc_mem_resp_pipe.sv
// rtl/parc_mem_resp_pipe.sv - fixed-latency response shift register
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_val, in_msg    response entering the pipe (one per accepted request)
//   out_val, out_msg  response leaving the pipe p_lat cycles later
// Each stage's message only loads behind a valid entry, so out_msg holds the
// last emitted response while out_val is low. Reset drops everything in flight.
module parc_mem_resp_pipe #(
  parameter int p_lat = 2,
  parameter int p_w   = 35
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_val,
  input  logic [p_w-1:0] in_msg,
  output logic           out_val,
  output logic [p_w-1:0] out_msg
);

  logic [p_lat-1:0] val_q;
  logic [p_w-1:0]   msg_q [p_lat];

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= '0;
      for (int i = 0; i < p_lat; i++) begin
        msg_q[i] <= '0;
      end
    end else begin
      val_q[0] <= in_val;
      if (in_val) begin
        msg_q[0] <= in_msg;
      end
      for (int i = 1; i < p_lat; i++) begin
        val_q[i] <= val_q[i-1];
        if (val_q[i-1]) begin
          msg_q[i] <= msg_q[i-1];
        end
      end
    end
  end

  assign out_val = val_q[p_lat-1];
  assign out_msg = msg_q[p_lat-1];

endmodule

// File: rtl/parc_mem_responder.sv
// rtl/parc_mem_responder.sv - single-port PARCv2 memory responder
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   memreq_msg    67-bit request {type, addr, len, data}
//   memreq_val    request valid
//   memreq_rdy    request ready (low only during reset)
//   memresp_msg   35-bit registered response {type, len, data}
//   memresp_val   response valid, exactly p_lat cycles after acceptance
//   err           sticky flag for word-crossing or out-of-range requests
// The array is read combinationally at acceptance and written at the end of
// the accepting cycle, so a read always sees writes accepted earlier.
module parc_mem_responder
  import parc_mem_responder_pkg::*;
#(
  parameter int p_mem_sz = 65536,
  parameter int p_lat    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [MEMREQ_NBITS-1:0]  memreq_msg,
  input  logic                     memreq_val,
  output logic                     memreq_rdy,
  output logic [MEMRESP_NBITS-1:0] memresp_msg,
  output logic                     memresp_val,
  output logic                     err
);

  localparam int c_aw = $clog2(p_mem_sz);

  logic [7:0] mem [p_mem_sz];

  mem_req_t                 req;
  logic                     accept;
  logic [2:0]               nbytes;
  logic                     crossing;
  logic                     out_of_range;
  logic                     illegal;
  logic [c_aw-1:0]          base;
  logic [31:0]              rdata;
  logic [MEMRESP_NBITS-1:0] resp_bits;

  assign req        = mem_req_unpack(memreq_msg);
  assign memreq_rdy = !reset;
  assign accept     = memreq_val && memreq_rdy;
  assign nbytes     = mem_len_bytes(req.len);

  // Illegal requests are still answered, but with zero data and no side effect.
  assign crossing     = ({1'b0, req.addr[1:0]} + nbytes) > 3'd4;
  assign out_of_range = req.addr >= 32'(p_mem_sz);
  assign illegal      = crossing || out_of_range;
  assign base         = req.addr[c_aw-1:0];

  // Right-justified read; bytes beyond the requested count stay zero.
  always_comb begin
    rdata = '0;
    if (!illegal && (req.typ == MEM_TYPE_READ)) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < nbytes) begin
          rdata[8*k +: 8] = mem[base + c_aw'(k)];
        end
      end
    end
  end

  assign resp_bits = mem_resp_pack(req.typ, req.len, rdata);

  // Array contents survive reset; the harness preloads them.
  always_ff @(posedge clk) begin
    if (accept && !illegal && (req.typ == MEM_TYPE_WRITE)) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < nbytes) begin
          mem[base + c_aw'(k)] <= req.data[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (accept && illegal) begin
      err <= 1'b1;
    end
  end

  parc_mem_resp_pipe #(
    .p_lat (p_lat),
    .p_w   (MEMRESP_NBITS)
  ) u_resp_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_val  (accept),
    .in_msg  (resp_bits),
    .out_val (memresp_val),
    .out_msg (memresp_msg)
  );

endmodule

// File: tb/tb_parc_mem_responder.sv
// tb/tb_parc_mem_responder.sv - randomized self-checking bench for parc_mem_responder
module tb_parc_mem_responder;

  localparam int LAT = 2;
  localparam int MEM_SZ = 65536;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [66:0] memreq_msg = '0;
  logic        memreq_val = 1'b0;
  logic        memreq_rdy;
  logic [34:0] memresp_msg;
  logic        memresp_val;
  logic        err;

  logic        reset1 = 1'b1;
  logic [66:0] memreq_msg1 = '0;
  logic        memreq_val1 = 1'b0;
  logic        memreq_rdy1;
  logic [34:0] memresp_msg1;
  logic        memresp_val1;
  logic        err1;

  parc_mem_responder #(.p_mem_sz(MEM_SZ), .p_lat(LAT)) dut (
    .clk(clk), .reset(reset),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val), .err(err)
  );

  parc_mem_responder #(.p_mem_sz(MEM_SZ), .p_lat(1)) dut1 (
    .clk(clk), .reset(reset1),
    .memreq_msg(memreq_msg1), .memreq_val(memreq_val1), .memreq_rdy(memreq_rdy1),
    .memresp_msg(memresp_msg1), .memresp_val(memresp_val1), .err(err1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a flat byte array plus a queue of expected responses
  // tagged with the cycle in which each must appear.
  typedef struct {
    int          due;
    logic [34:0] msg;
  } exp_t;

  bit   [7:0]  model_mem [MEM_SZ];
  exp_t        exp_q [$];
  logic        model_err = 1'b0;
  logic [34:0] last_msg = '0;
  logic [31:0] got_data = '0;

  function automatic logic [66:0] mk_req(input logic typ, input logic [31:0] addr,
                                         input logic [1:0] len, input logic [31:0] data);
    return {typ, addr, len, data};
  endfunction

  task automatic model_accept(input logic [66:0] m);
    logic        typ;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
    logic [31:0] rd;
    int          n;
    bit          bad;
    exp_t        e;
    {typ, addr, len, data} = m;
    n   = (len == 2'd0) ? 4 : int'(len);
    bad = (int'(addr[1:0]) + n > 4) || (addr >= 32'(MEM_SZ));
    rd  = 0;
    if (bad) begin
      model_err = 1'b1;
    end else begin
      for (int k = 0; k < n; k++) begin
        if (typ == 1'b0) rd[8*k +: 8] = model_mem[int'(addr) + k];
        else model_mem[int'(addr) + k] = data[8*k +: 8];
      end
    end
    e.due = cyc + LAT;
    e.msg = {typ, len, (typ == 1'b0) ? rd : 32'h0};
    exp_q.push_back(e);
  endtask

  // One clock cycle on the main DUT: drive, predict, clock, compare.
  task automatic step(input logic rst, input logic v, input logic [66:0] m);
    logic exp_val;
    reset      = rst;
    memreq_val = v;
    memreq_msg = m;
    #1;
    check("rdy", memreq_rdy, !rst);
    if (!rst && v) model_accept(m);
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      model_err = 1'b0;
      last_msg  = '0;
    end
    #1;
    exp_val = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check("resp_val", memresp_val, exp_val);
    if (exp_val) begin
      check("resp_msg", memresp_msg, exp_q[0].msg);
      last_msg = exp_q[0].msg;
      void'(exp_q.pop_front());
    end else begin
      check("resp_hold", memresp_msg, last_msg);
    end
    check("err", err, model_err);
    if (memresp_val) got_data = memresp_msg[31:0];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  initial begin
    // Reset values
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    check("rst_val", memresp_val, 1'b0);
    check("rst_msg", memresp_msg, 35'h0);
    check("rst_err", err, 1'b0);

    // Preload 0x1000..0x10ff with random words
    for (int a = 32'h1000; a < 32'h1100; a += 4)
      step(1'b0, 1'b1, mk_req(1'b1, 32'(a), 2'd0, $urandom));
    idle(LAT + 1);

    // Word write then read
    step(1'b0, 1'b1, mk_req(1'b1, 32'h1000, 2'd0, 32'hdeadbeef));
    step(1'b0, 1'b1, mk_req(1'b0, 32'h1000, 2'd0, 32'h0));
    idle(LAT + 1);
    check("word_rd", got_data, 32'hdeadbeef);

    // Byte write merge and halfword read
    step(1'b0, 1'b1, mk_req(1'b1, 32'h1001, 2'd1, 32'h000000aa));
    step(1'b0, 1'b1, mk_req(1'b0, 32'h1000, 2'd0, 32'h0));
    idle(LAT + 1);
    check("merge_rd", got_data, 32'hdeadaaef);
    step(1'b0, 1'b1, mk_req(1'b0, 32'h1002, 2'd2, 32'h0));
    idle(LAT + 1);
    check("half_rd", got_data, 32'h0000dead);

    // Streaming reads, no bubbles
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, mk_req(1'b0, 32'h1000 + 32'(4 * i), 2'd0, 32'h0));
    idle(LAT + 1);

    // Reset while a read is in flight
    step(1'b0, 1'b1, mk_req(1'b0, 32'h1000, 2'd0, 32'h0));
    step(1'b1, 1'b0, '0);
    idle(LAT + 2);
    step(1'b0, 1'b1, mk_req(1'b0, 32'h1000, 2'd0, 32'h0));
    idle(LAT + 1);
    check("post_rst_rd", got_data, 32'hdeadaaef);

    // Error cases
    step(1'b0, 1'b1, mk_req(1'b0, 32'h00010000, 2'd0, 32'h0));
    idle(LAT + 1);
    check("oor_data", got_data, 32'h0);
    check("oor_err", err, 1'b1);
    step(1'b0, 1'b1, mk_req(1'b1, 32'h1003, 2'd2, 32'hffffffff));
    step(1'b0, 1'b1, mk_req(1'b0, 32'h1000, 2'd0, 32'h0));
    idle(LAT + 1);
    check("cross_unchanged", got_data, 32'hdeadaaef);
    check("err_sticky", err, 1'b1);
    step(1'b1, 1'b0, '0);
    check("err_cleared", err, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic        rst;
      logic        v;
      logic [31:0] addr;
      rst  = ($urandom_range(0, 59) == 0);
      v    = ($urandom_range(0, 3) != 0);
      addr = ($urandom_range(0, 15) == 0) ? 32'h00010000 + 32'($urandom_range(0, 4095))
                                          : 32'h1000 + 32'($urandom_range(0, 255));
      step(rst, v, mk_req(1'($urandom), addr, 2'($urandom), $urandom));
    end
    idle(LAT + 2);

    // p_lat = 1 instance
    reset1 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("l1_rst_val", memresp_val1, 1'b0);
    check("l1_rst_rdy", memreq_rdy1, 1'b0);
    reset1      = 1'b0;
    memreq_val1 = 1'b1;
    memreq_msg1 = mk_req(1'b1, 32'h2000, 2'd0, 32'h12345678);
    #1;
    check("l1_rdy", memreq_rdy1, 1'b1);
    @(posedge clk); #1;
    check("l1_wr_val", memresp_val1, 1'b1);
    check("l1_wr_msg", memresp_msg1, {1'b1, 2'd0, 32'h0});
    memreq_msg1 = mk_req(1'b0, 32'h2000, 2'd0, 32'h0);
    @(posedge clk); #1;
    check("l1_rd_val", memresp_val1, 1'b1);
    check("l1_rd_msg", memresp_msg1, {1'b0, 2'd0, 32'h12345678});
    memreq_val1 = 1'b0;
    @(posedge clk); #1;
    check("l1_idle_val", memresp_val1, 1'b0);
    check("l1_hold_msg", memresp_msg1, {1'b0, 2'd0, 32'h12345678});
    check("l1_err", err1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
